mux_rr_arbiter: RTL

Round-robin arbiter and sequencer for the 4:1 gate-level select mux. Four requesters (A, B, C, D) share one registered output channel. The block picks a winner, drives the mux select pair, loads the winner's data into an output register, and presents it downstream with a valid/ready handshake. A burst limit stops one requester from monopolising the channel while others are waiting.

---
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 select mux: picks a winner among
// four requesters, loads its data into a registered output, and hands it off with valid/ready.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] dA,
    input  logic [WIDTH-1:0] dB,
    input  logic [WIDTH-1:0] dC,
    input  logic [WIDTH-1:0] dD,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic [3:0]       gnt
);

    localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [1:0]       owner, owner_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] data_next;
    logic [1:0]       sel_next;
    logic [3:0]       gnt_next;

    logic             load;
    logic             keep;
    logic             found;
    logic [1:0]       scan_idx;
    logic [1:0]       scan_win;
    logic [1:0]       win;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            owner    <= 2'd3;
            cnt      <= '0;
            out_data <= '0;
            sel      <= 2'd0;
            gnt      <= 4'd0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            cnt      <= cnt_next;
            out_data <= data_next;
            sel      <= sel_next;
            gnt      <= gnt_next;
        end
    end

    assign out_valid = (state == FULL);

    // Arbitration, next-state and ack
    always_comb begin
        state_next = state;
        owner_next = owner;
        cnt_next   = cnt;
        data_next  = out_data;
        sel_next   = sel;
        gnt_next   = gnt;
        ack        = 4'd0;
        found      = 1'b0;
        scan_idx   = owner;
        scan_win   = owner;

        load = (|req) && ((state == EMPTY) || out_ready);
        // The owner only retains the channel across back-to-back loads, never after a drain.
        keep = (state == FULL) && req[owner] && (cnt < CNT_W'(BURST - 1));

        for (int i = 1; i <= 4; i++) begin
            scan_idx = owner + 2'(i);
            if (!found && req[scan_idx]) begin
                found    = 1'b1;
                scan_win = scan_idx;
            end
        end

        win = keep ? owner : scan_win;

        if (load) begin
            state_next = FULL;
            owner_next = win;
            cnt_next   = keep ? CNT_W'(cnt + 1'b1) : '0;
            sel_next   = win;
            gnt_next   = 4'(4'd1 << win);
            ack        = 4'(4'd1 << win);
            case (win)
                2'd0:    data_next = dA;
                2'd1:    data_next = dB;
                2'd2:    data_next = dC;
                default: data_next = dD;
            endcase
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
            gnt_next   = 4'd0;
        end

        if (!rst_n) begin
            ack = 4'd0;
        end
    end

endmodule
